apb_slave_regbank: RTL and testbench
====================================

Name: apb_slave_regbank

Overview:
Parametrised APB slave model that replaces the pass-through interface with real storage. It holds NUM_SLAVES independent register banks of DEPTH words each, selected by a one-hot psel bus. It supports programmable wait states (pready), byte strobes, and error responses (pslverr). It sits at the APB side of the AHB-to-APB bridge testbench as the target for bridge read and write traffic.

Parameters:
NUM_SLAVES, 3, width of the psel bus and number of register banks
ADDR_WIDTH, 32, paddr width
DATA_WIDTH, 32, pwdata/prdata width; must be 32 or 64
DEPTH, 16, words per bank; power of 2, at least 2
WAIT_CYCLES, 0, wait states inserted in every access phase (0..15)
RESET_VALUE, 0, reset contents of every register word

Ports:
pclk  in  1  APB clock, rising edge
presetn  in  1  asynchronous active-low reset
psel  in  NUM_SLAVES  one-hot slave select
penable  in  1  access-phase indicator
pwrite  in  1  1=write, 0=read
paddr  in  ADDR_WIDTH  byte address
pwdata  in  DATA_WIDTH  write data
pstrb  in  DATA_WIDTH/8  write byte strobes
prdata  out  DATA_WIDTH  read data; valid only while pready=1 and pwrite=0, 0 otherwise
pready  out  1  transfer-complete indicator
pslverr  out  1  error response; valid only while pready=1, 0 otherwise

Behaviour:
- Reset (presetn=0, asynchronous): FSM=IDLE, wait counter=0, all bank words=RESET_VALUE. pready=0, pslverr=0, prdata=0. Reset mid-transfer aborts the transfer and drops any pending write.
- Terms: LSB=log2(DATA_WIDTH/8). word index=paddr[LSB +: log2(DEPTH)].
- FSM has two states.
- IDLE:
  - If |psel and !penable (setup phase): go to ACCESS and load counter=WAIT_CYCLES.
  - penable=1 without a preceding setup is ignored: stay IDLE, pready=0.
- ACCESS:
  - pready=(counter==0). pready is a function of registered state only, with no combinational path from inputs.
  - If counter!=0: decrement.
  - If psel drops to 0 before completion: abort, return to IDLE, no write, no response.
  - Completion is the rising edge with psel, penable and pready all high. Go to IDLE, which permits a back-to-back setup on the next cycle.
- Error (pslverr=1 during the completing cycle) when any of the following holds:
  - psel is not exactly one-hot;
  - paddr[LSB-1:0]!=0 (misaligned);
  - any paddr bit above LSB+log2(DEPTH)-1 is set (out of range).
  - The error check is evaluated on live inputs during the pready cycle. APB requires the inputs to be stable, so this equals the setup values.
  - On error: no write occurs and prdata=0.
- Write: at the completing edge, if no error, each byte i with pstrb[i]=1 updates bank[sel][word][8i+7:8i]. Bytes with pstrb[i]=0 are unchanged. All-zero pstrb is legal and writes nothing.
- Read: during the pready cycle with pwrite=0 and no error, prdata=bank[sel][word] (combinational from storage). Otherwise prdata=0, never X or Z.
- Wait timing: pready rises in the (WAIT_CYCLES+1)th access cycle. With WAIT_CYCLES=0 the transfer takes two cycles total (setup plus one access).
- Banks are fully independent: a write to one bank never alters another.
- Read-after-write to the same address in the following transfer returns the new data.

Test Plan:
- Reset: assert presetn=0 mid-access (WAIT_CYCLES=3) -> pready=0, pslverr=0, prdata=0 immediately. A subsequent read of bank0 word0 returns RESET_VALUE (0), and the aborted write did not land.
- Basic access, WAIT_CYCLES=2: write psel=3'b010, paddr=0x08, pwdata=0xDEADBEEF, pstrb=4'hF. pready is high in the 3rd access cycle, pslverr=0. Read back the same address -> prdata=0xDEADBEEF. Bank0 and bank2 word2 still read 0.
- Byte strobes: write 0x11223344 with pstrb=4'b0101 over 0xDEADBEEF -> read 0xDE22BE44.
- Errors:
  - paddr=0x40 (DEPTH=16) -> pslverr=1, prdata=0.
  - paddr=0x06 -> pslverr=1.
  - psel=3'b011 -> pslverr=1.
  - Each case leaves storage unchanged.
- Protocol corner cases:
  - psel dropped in the 2nd wait cycle -> no pready, no write, and the next transfer runs normally.
  - penable=1 with no setup -> pready stays 0.
- Back-to-back: with WAIT_CYCLES=0, issue 8 consecutive write/read pairs to random words across all banks with no idle cycles -> every read matches the last write, and each transfer takes exactly 2 cycles.

Source files
------------

// File: rtl/apb_slave_regbank_if.sv
// apb_slave_regbank_if: APB bus signals between a master and the register-bank slave
interface apb_slave_regbank_if #(
  parameter int NUM_SLAVES = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_SLAVES-1:0]   psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pready;
  logic                    pslverr;
  modport master (output psel, penable, pwrite, paddr, pwdata, pstrb, input prdata, pready, pslverr);
  modport slave  (input psel, penable, pwrite, paddr, pwdata, pstrb, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_slave_regbank.sv
// apb_slave_regbank: APB slave with NUM_SLAVES independent register banks, wait states, byte strobes and error responses
module apb_slave_regbank #(
  parameter int                          NUM_SLAVES  = 3,
  parameter int                          ADDR_WIDTH  = 32,
  parameter int                          DATA_WIDTH  = 32,
  parameter int                          DEPTH       = 16,
  parameter int                          WAIT_CYCLES = 0,
  parameter logic [DATA_WIDTH-1:0]       RESET_VALUE = '0
) (
  input logic pclk,
  input logic presetn,
  apb_slave_regbank_if.slave bus
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(NB);
  localparam int IW  = $clog2(DEPTH);
  localparam int SW  = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t                state;
  logic [3:0]            cnt;
  logic [DATA_WIDTH-1:0] mem [NUM_SLAVES][DEPTH];
  logic [SW-1:0]         sel;
  logic [IW-1:0]         word;
  logic                  onehot, err, ready, wr_en;
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) sel = bus.psel[i] ? SW'(i) : sel;
  end
  assign word   = bus.paddr[LSB +: IW];
  assign onehot = (bus.psel != '0) && ((bus.psel & (bus.psel - 1'b1)) == '0);
  assign err    = !onehot || (bus.paddr[LSB-1:0] != '0) || ((bus.paddr >> (LSB + IW)) != '0);
  // pready depends only on registered state, never on live inputs
  assign ready  = (state == ACCESS) && (cnt == 4'd0);
  assign wr_en  = ready && bus.penable && bus.pwrite && !err;
  assign bus.pready  = ready;
  assign bus.pslverr = ready && err;
  assign bus.prdata  = (ready && !bus.pwrite && !err) ? mem[sel][word] : '0;
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (|bus.psel && !bus.penable) begin
        state <= ACCESS;
        cnt   <= 4'(WAIT_CYCLES);
      end
    end else if (!(|bus.psel)) state <= IDLE;
    else if (cnt != 4'd0) cnt <= cnt - 4'd1;
    else if (bus.penable) state <= IDLE;
  always_ff @(posedge pclk or negedge presetn)
    if (!presetn) begin
      for (int s = 0; s < NUM_SLAVES; s++)
        for (int w = 0; w < DEPTH; w++) mem[s][w] <= RESET_VALUE;
    end else if (wr_en) begin
      for (int b = 0; b < NB; b++)
        if (bus.pstrb[b]) mem[sel][word][8*b +: 8] <= bus.pwdata[8*b +: 8];
    end
endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb_apb_slave_regbank: directed checks of three regbank instances with 3, 2 and 0 wait states
module tb_apb_slave_regbank;
  logic        pclk = 0;
  logic        presetn = 0;
  logic [2:0]  psel = '0;
  logic        penable = 0, pwrite = 0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [3:0]  pstrb = '0;
  int          tgt = 0;
  int          tests = 0, fails = 0;
  logic [31:0] rdata;
  logic        rdy, err;
  always #5 pclk = ~pclk;
  apb_slave_regbank_if #(.NUM_SLAVES(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) i0 ();
  apb_slave_regbank_if #(.NUM_SLAVES(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) i1 ();
  apb_slave_regbank_if #(.NUM_SLAVES(3), .ADDR_WIDTH(32), .DATA_WIDTH(32)) i2 ();
  assign i0.psel = tgt == 0 ? psel : '0;
  assign i1.psel = tgt == 1 ? psel : '0;
  assign i2.psel = tgt == 2 ? psel : '0;
  assign {i0.penable, i0.pwrite, i0.paddr, i0.pwdata, i0.pstrb} = {penable, pwrite, paddr, pwdata, pstrb};
  assign {i1.penable, i1.pwrite, i1.paddr, i1.pwdata, i1.pstrb} = {penable, pwrite, paddr, pwdata, pstrb};
  assign {i2.penable, i2.pwrite, i2.paddr, i2.pwdata, i2.pstrb} = {penable, pwrite, paddr, pwdata, pstrb};
  assign rdata = tgt == 0 ? i0.prdata  : tgt == 1 ? i1.prdata  : i2.prdata;
  assign rdy   = tgt == 0 ? i0.pready  : tgt == 1 ? i1.pready  : i2.pready;
  assign err   = tgt == 0 ? i0.pslverr : tgt == 1 ? i1.pslverr : i2.pslverr;
  apb_slave_regbank #(.WAIT_CYCLES(3)) dut0 (.pclk(pclk), .presetn(presetn), .bus(i0.slave));
  apb_slave_regbank #(.WAIT_CYCLES(2)) dut1 (.pclk(pclk), .presetn(presetn), .bus(i1.slave));
  apb_slave_regbank #(.WAIT_CYCLES(0)) dut2 (.pclk(pclk), .presetn(presetn), .bus(i2.slave));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Called just after a rising edge; returns just after the completing edge so a new setup can follow directly
  task automatic xfer(input logic [2:0] s, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] st, output logic [31:0] rd, output logic er, output int acc);
    psel = s; penable = 0; pwrite = w; paddr = a; pwdata = d; pstrb = st;
    @(posedge pclk); #1 penable = 1;
    acc = 0; rd = 'x; er = 'x;
    forever begin
      @(negedge pclk);
      acc++;
      if (rdy) begin
        rd = rdata; er = err;
        break;
      end
      if (acc >= 20) begin
        tests++; fails++;
        $error("FAIL timeout: pready never rose after %0d access cycles", acc);
        break;
      end
      @(posedge pclk); #1;
    end
    @(posedge pclk); #1;
  endtask
  task automatic idle();
    psel = '0; penable = 0;
    @(posedge pclk); #1;
  endtask
  logic [2:0]  bs [8] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b010, 3'b001};
  logic [31:0] ba [8] = '{32'h00, 32'h3C, 32'h14, 32'h20, 32'h04, 32'h08, 32'h30, 32'h00};
  logic [31:0] bd [8] = '{32'h01234567, 32'h89ABCDEF, 32'h0F0F0F0F, 32'hA5A5A5A5,
                          32'h13579BDF, 32'h2468ACE0, 32'hFFFFFFFF, 32'h76543210};
  initial begin
    logic [31:0] rd;
    logic        er;
    int          acc;
    repeat (2) @(negedge pclk);
    chk("reset_pready", {31'b0, rdy}, 32'd0);
    chk("reset_pslverr", {31'b0, err}, 32'd0);
    chk("reset_prdata", rdata, 32'd0);
    @(posedge pclk); #1 presetn = 1;
    @(posedge pclk); #1;
    // reset lands while a write to bank0 word0 is in its ready cycle (3 wait states)
    tgt = 0;
    psel = 3'b001; penable = 0; pwrite = 1; paddr = 32'h0; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("pre_reset_ready", {31'b0, rdy}, 32'd1);
    #1 presetn = 0;
    #1;
    chk("midreset_pready", {31'b0, rdy}, 32'd0);
    chk("midreset_pslverr", {31'b0, err}, 32'd0);
    chk("midreset_prdata", rdata, 32'd0);
    psel = '0; penable = 0;
    @(posedge pclk); #1 presetn = 1;
    @(posedge pclk); #1;
    xfer(3'b001, 0, 32'h0, 32'h0, 4'h0, rd, er, acc);
    chk("after_reset_rd", rd, 32'd0);
    chk("after_reset_acc", acc, 32'd4);
    idle();
    // basic access, 2 wait states
    tgt = 1;
    xfer(3'b010, 1, 32'h08, 32'hDEADBEEF, 4'hF, rd, er, acc);
    chk("wr_acc", acc, 32'd3);
    chk("wr_err", {31'b0, er}, 32'd0);
    chk("wr_prdata_zero", rd, 32'd0);
    xfer(3'b010, 0, 32'h08, 32'h0, 4'h0, rd, er, acc);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_acc", acc, 32'd3);
    chk("rd_err", {31'b0, er}, 32'd0);
    xfer(3'b001, 0, 32'h08, 32'h0, 4'h0, rd, er, acc);
    chk("bank0_untouched", rd, 32'd0);
    xfer(3'b100, 0, 32'h08, 32'h0, 4'h0, rd, er, acc);
    chk("bank2_untouched", rd, 32'd0);
    // byte strobes
    xfer(3'b010, 1, 32'h08, 32'h11223344, 4'b0101, rd, er, acc);
    xfer(3'b010, 0, 32'h08, 32'h0, 4'h0, rd, er, acc);
    chk("strobe_merge", rd, 32'hDE22BE44);
    // error responses
    xfer(3'b010, 1, 32'h40, 32'hFFFFFFFF, 4'hF, rd, er, acc);
    chk("oor_wr_err", {31'b0, er}, 32'd1);
    xfer(3'b010, 0, 32'h40, 32'h0, 4'h0, rd, er, acc);
    chk("oor_rd_err", {31'b0, er}, 32'd1);
    chk("oor_rd_data", rd, 32'd0);
    xfer(3'b010, 1, 32'h06, 32'hFFFFFFFF, 4'hF, rd, er, acc);
    chk("misalign_err", {31'b0, er}, 32'd1);
    xfer(3'b011, 1, 32'h08, 32'hFFFFFFFF, 4'hF, rd, er, acc);
    chk("multisel_wr_err", {31'b0, er}, 32'd1);
    xfer(3'b011, 0, 32'h08, 32'h0, 4'h0, rd, er, acc);
    chk("multisel_rd_err", {31'b0, er}, 32'd1);
    chk("multisel_rd_data", rd, 32'd0);
    xfer(3'b010, 0, 32'h00, 32'h0, 4'h0, rd, er, acc);
    chk("oor_no_write", rd, 32'd0);
    xfer(3'b010, 0, 32'h04, 32'h0, 4'h0, rd, er, acc);
    chk("misalign_no_write", rd, 32'd0);
    xfer(3'b010, 0, 32'h08, 32'h0, 4'h0, rd, er, acc);
    chk("multisel_no_write_b1", rd, 32'hDE22BE44);
    xfer(3'b001, 0, 32'h08, 32'h0, 4'h0, rd, er, acc);
    chk("multisel_no_write_b0", rd, 32'd0);
    idle();
    // psel dropped in the second wait cycle
    psel = 3'b010; penable = 0; pwrite = 1; paddr = 32'h0C; pwdata = 32'h12345678; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1;
    @(negedge pclk);
    chk("abort_cyc1_ready", {31'b0, rdy}, 32'd0);
    @(posedge pclk); #1 psel = '0;
    @(negedge pclk);
    chk("abort_cyc2_ready", {31'b0, rdy}, 32'd0);
    @(posedge pclk); #1;
    idle();
    xfer(3'b010, 0, 32'h0C, 32'h0, 4'h0, rd, er, acc);
    chk("abort_no_write", rd, 32'd0);
    chk("abort_next_acc", acc, 32'd3);
    idle();
    // penable without a setup phase is ignored
    psel = 3'b010; penable = 1; pwrite = 1; paddr = 32'h10; pwdata = 32'hAAAAAAAA; pstrb = 4'hF;
    repeat (5) @(posedge pclk);
    @(negedge pclk);
    chk("nosetup_ready", {31'b0, rdy}, 32'd0);
    @(posedge pclk); #1;
    idle();
    xfer(3'b010, 0, 32'h10, 32'h0, 4'h0, rd, er, acc);
    chk("nosetup_no_write", rd, 32'd0);
    // back-to-back, zero wait states, no idle cycles
    tgt = 2;
    for (int k = 0; k < 8; k++) begin
      xfer(bs[k], 1, ba[k], bd[k], 4'hF, rd, er, acc);
      chk($sformatf("b2b_wr%0d_acc", k), acc, 32'd1);
      xfer(bs[k], 0, ba[k], 32'h0, 4'h0, rd, er, acc);
      chk($sformatf("b2b_rd%0d_acc", k), acc, 32'd1);
      chk($sformatf("b2b_rd%0d_data", k), rd, bd[k]);
    end
    xfer(3'b010, 0, 32'h3C, 32'h0, 4'h0, rd, er, acc);
    chk("b2b_persist_b1", rd, 32'h89ABCDEF);
    xfer(3'b100, 0, 32'h14, 32'h0, 4'h0, rd, er, acc);
    chk("b2b_persist_b2", rd, 32'h0F0F0F0F);
    xfer(3'b001, 0, 32'h00, 32'h0, 4'h0, rd, er, acc);
    chk("b2b_overwrite_b0", rd, 32'h76543210);
    idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
